pulse_sequencer: RTL and testbench
==================================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent trigger/pulse channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of every timing counter and config register.
REQ-003 The block SHALL have parameter AW, default $clog2(NUM_CH)+2, giving the config write address width.
REQ-004 iCLK  input  1  the single clock domain for the block; 80 MHz internal oscillator in the current system.
REQ-005 iRESETn  input  1  reset, asynchronous and active-low.
REQ-006 iTRIG  input  NUM_CH  asynchronous per-channel trigger inputs from MKR pins.
REQ-007 iABORT  input  NUM_CH  synchronous per-channel abort, active-high.
REQ-008 iWR  input  1  config write strobe, one word per cycle.
REQ-009 iWR_ADDR  input  AW  {channel, reg}; reg 0=DELAY, 1=WIDTH, 2=GAP, 3=REPEAT.
REQ-010 iWR_DATA  input  CNT_W  config write data.
REQ-011 oPULSE  output  NUM_CH  registered pulse outputs.
REQ-012 oBUSY  output  NUM_CH  channel sequence in progress.
REQ-013 oDONE  output  NUM_CH  one-cycle completion strobe.

Function
REQ-014 Each channel SHALL synchronise iTRIG through two flops and detect rising edges with a third flop; only rising edges trigger.
REQ-015 Each channel SHALL run an FSM with states IDLE, DELAY, PULSE, GAP.
REQ-016 On a detected edge in IDLE with WIDTH!=0, the channel SHALL snapshot DELAY/WIDTH/GAP/REPEAT and leave IDLE.
REQ-017 The transition out of IDLE SHALL go to DELAY if DELAY!=0, else directly to PULSE.
REQ-018 With k the first edge sampling iTRIG high, oPULSE SHALL rise at edge k+2+DELAY.
REQ-019 oPULSE SHALL stay high for exactly WIDTH cycles per pulse.
REQ-020 Consecutive pulses SHALL be separated by GAP low cycles; GAP=0 SHALL be treated as 1.
REQ-021 A sequence SHALL emit REPEAT+1 pulses; REPEAT is unsigned, the maximum value is 2^CNT_W-1 with no wrap.
REQ-022 At the edge where the last pulse falls, the FSM SHALL return to IDLE and oDONE SHALL be high for that one cycle.
REQ-023 oBUSY SHALL be high in every non-IDLE state.
REQ-024 Edges arriving while BUSY SHALL be ignored and SHALL NOT be queued.
REQ-025 An edge in the same cycle as oDONE SHALL be ignored.
REQ-026 An edge arriving while WIDTH=0 SHALL be ignored: no BUSY, no DONE.
REQ-027 Config writes SHALL take effect on the next edge and SHALL NOT alter a running sequence, which uses its snapshot.
REQ-028 Writes to a channel index >= NUM_CH SHALL be discarded.
REQ-029 iABORT SHALL force the channel to IDLE at the next edge with oPULSE low and no oDONE, and SHALL take priority over a simultaneous trigger.
REQ-030 Channels SHALL be fully independent; simultaneous triggers on all channels SHALL behave identically to separate triggers.

Reset
REQ-031 Asserting iRESETn low SHALL immediately clear oPULSE, oBUSY and oDONE to 0, place all FSMs in IDLE and clear the sync flops.
REQ-032 Reset SHALL set config to DELAY=0, WIDTH=0, GAP=1, REPEAT=0, so channels are disabled until written.
REQ-033 Reset asserted mid-pulse SHALL drop oPULSE asynchronously, with no oDONE after release.

Verification
REQ-034 Ch0 DELAY=3, WIDTH=5, REPEAT=0; iTRIG rises before edge k -> oPULSE[0] high edges k+5..k+9; oDONE[0] at k+10; oBUSY[0] from k+2 to k+9.
REQ-035 Ch1 DELAY=0, WIDTH=2, GAP=0, REPEAT=2 -> three 2-cycle pulses, each separated by 1 low cycle, first rising at k+2; a single oDONE.
REQ-036 Retrigger ch0 mid-sequence, and rewrite WIDTH=9 mid-sequence -> pulse count and width unchanged; the next trigger uses WIDTH=9.
REQ-037 iABORT[0] during PULSE -> oPULSE[0] low next edge, oBUSY low, no oDONE; a trigger in the same cycle is ignored.
REQ-038 After reset, trigger both channels -> no activity (WIDTH=0); write to address channel 3 with NUM_CH=2 -> no config change.
REQ-039 iRESETn low mid-pulse -> outputs 0 without a clock edge; after release, no spurious pulse or oDONE.

Source files
------------

// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_sequencer
//  Purpose  : Multi-channel triggered pulse-train generator. Each channel
//             synchronises an asynchronous trigger, and on a rising edge
//             emits REPEAT+1 pulses of WIDTH cycles after DELAY cycles,
//             separated by GAP low cycles, using a snapshot of its config.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_sequencer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int AW     = $clog2(NUM_CH) + 2
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic [NUM_CH-1:0] iTRIG,
  input  logic [NUM_CH-1:0] iABORT,
  input  logic              iWR,
  input  logic [AW-1:0]     iWR_ADDR,
  input  logic [CNT_W-1:0]  iWR_DATA,
  output logic [NUM_CH-1:0] oPULSE,
  output logic [NUM_CH-1:0] oBUSY,
  output logic [NUM_CH-1:0] oDONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [1:0]       REG_DELAY  = 2'd0;
  localparam logic [1:0]       REG_WIDTH  = 2'd1;
  localparam logic [1:0]       REG_GAP    = 2'd2;
  localparam logic [1:0]       REG_REPEAT = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Address split: upper bits select the channel, low two bits the register.
  // Channel indices with no matching generate instance are simply dropped.
  logic [AW-1:0] wr_ch;
  logic [1:0]    wr_reg;

  assign wr_ch  = iWR_ADDR >> 2;
  assign wr_reg = iWR_ADDR[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [CNT_W-1:0] cfg_repeat;
    logic             wr_sel;

    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             trig_edge;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] rep;
    logic [CNT_W-1:0] rep_nx;
    logic [CNT_W-1:0] width_s;
    logic [CNT_W-1:0] width_nx;
    logic [CNT_W-1:0] gap_s;
    logic [CNT_W-1:0] gap_nx;
    logic [CNT_W-1:0] gap_load;
    logic             pulse_q;
    logic             done_q;
    logic             done_nx;

    assign wr_sel    = iWR && (wr_ch == AW'(i));
    assign trig_edge = sync2 & ~sync3;
    // A GAP of zero behaves as a single low cycle.
    assign gap_load  = (gap_s == '0) ? '0 : (gap_s - CNT_ONE);

    // Config registers; reset leaves the channel disabled (WIDTH = 0).
    always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
        cfg_delay  <= '0;
        cfg_width  <= '0;
        cfg_gap    <= CNT_ONE;
        cfg_repeat <= '0;
      end else if (wr_sel) begin
        case (wr_reg)
          REG_DELAY:  cfg_delay  <= iWR_DATA;
          REG_WIDTH:  cfg_width  <= iWR_DATA;
          REG_GAP:    cfg_gap    <= iWR_DATA;
          REG_REPEAT: cfg_repeat <= iWR_DATA;
        endcase
      end
    end

    // Two-flop synchroniser plus one history flop for rising-edge detect.
    always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        sync3 <= 1'b0;
      end else begin
        sync1 <= iTRIG[i];
        sync2 <= sync1;
        sync3 <= sync2;
      end
    end

    // Next-state logic: abort wins; counters count down to zero per phase.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rep_nx   = rep;
      width_nx = width_s;
      gap_nx   = gap_s;
      done_nx  = 1'b0;
      if (iABORT[i]) begin
        state_nx = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // Ignore edges coinciding with the completion strobe.
            if (trig_edge && !done_q && (cfg_width != '0)) begin
              width_nx = cfg_width;
              gap_nx   = cfg_gap;
              rep_nx   = cfg_repeat;
              if (cfg_delay != '0) begin
                state_nx = ST_DELAY;
                cnt_nx   = cfg_delay - CNT_ONE;
              end else begin
                state_nx = ST_PULSE;
                cnt_nx   = cfg_width - CNT_ONE;
              end
            end
          end
          ST_DELAY: begin
            if (cnt == '0) begin
              state_nx = ST_PULSE;
              cnt_nx   = width_s - CNT_ONE;
            end else begin
              cnt_nx = cnt - CNT_ONE;
            end
          end
          ST_PULSE: begin
            if (cnt == '0) begin
              if (rep == '0) begin
                state_nx = ST_IDLE;
                done_nx  = 1'b1;
              end else begin
                rep_nx   = rep - CNT_ONE;
                state_nx = ST_GAP;
                cnt_nx   = gap_load;
              end
            end else begin
              cnt_nx = cnt - CNT_ONE;
            end
          end
          ST_GAP: begin
            if (cnt == '0) begin
              state_nx = ST_PULSE;
              cnt_nx   = width_s - CNT_ONE;
            end else begin
              cnt_nx = cnt - CNT_ONE;
            end
          end
          default: state_nx = ST_IDLE;
        endcase
      end
    end

    // State, snapshot and registered outputs; pulse follows the next state.
    always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        rep     <= '0;
        width_s <= '0;
        gap_s   <= '0;
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        rep     <= rep_nx;
        width_s <= width_nx;
        gap_s   <= gap_nx;
        pulse_q <= (state_nx == ST_PULSE);
        done_q  <= done_nx;
      end
    end

    assign oPULSE[i] = pulse_q;
    assign oBUSY[i]  = (state != ST_IDLE);
    assign oDONE[i]  = done_q;
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_sequencer
//  Purpose  : Self-checking bench for pulse_sequencer. A timeline model
//             computes each channel's pulse train arithmetically from the
//             accepted trigger time and snapshot config; directed cases pin
//             exact cycle positions, then randomized traffic runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sequencer;

  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int AWB = 4;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] trig;
  logic [NCH-1:0] abort;
  logic           wr;
  logic [AWB-1:0] wr_addr;
  logic [CW-1:0]  wr_data;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pulse_sequencer #(.NUM_CH(NCH), .CNT_W(CW), .AW(AWB)) dut (
    .iCLK    (clk),
    .iRESETn (rst_n),
    .iTRIG   (trig),
    .iABORT  (abort),
    .iWR     (wr),
    .iWR_ADDR(wr_addr),
    .iWR_DATA(wr_data),
    .oPULSE  (pulse),
    .oBUSY   (busy),
    .oDONE   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // An accepted sequence starting at edge s is idle-busy for DELAY cycles,
  // then repeats a period of WIDTH high + max(GAP,1) low; it ends after the
  // last pulse, i.e. at s + DELAY + (R+1)*WIDTH + R*GAP'.
  longint         n;
  bit             m_act [NCH];
  longint         m_st  [NCH];
  longint         m_dl  [NCH];
  longint         m_wd  [NCH];
  longint         m_gp  [NCH];
  longint         m_end [NCH];
  longint         m_done[NCH];
  longint         m_cd  [NCH];
  longint         m_cw  [NCH];
  longint         m_cg  [NCH];
  longint         m_cr  [NCH];
  logic [NCH-1:0] h1, h2, h3;   // iTRIG as sampled 1, 2, 3 edges ago

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_act[c]  = 1'b0;
      m_done[c] = -10;
      m_cd[c]   = 0;
      m_cw[c]   = 0;
      m_cg[c]   = 1;
      m_cr[c]   = 0;
    end
    h1 = '0;
    h2 = '0;
    h3 = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] det;
    int             ch;
    longint         rp;
    n++;
    // iTRIG first seen high at edge k starts the sequence at edge k+2.
    det = h2 & ~h3;
    for (int c = 0; c < NCH; c++) begin
      if (m_act[c]) begin
        if (abort[c]) m_act[c] = 1'b0;
        else if (n == m_end[c]) begin
          m_act[c]  = 1'b0;
          m_done[c] = n;
        end
      end else if (det[c] && !abort[c] && (m_done[c] != n - 1) && (m_cw[c] != 0)) begin
        m_act[c] = 1'b1;
        m_st[c]  = n;
        m_dl[c]  = m_cd[c];
        m_wd[c]  = m_cw[c];
        m_gp[c]  = (m_cg[c] == 0) ? 1 : m_cg[c];
        rp       = m_cr[c];
        m_end[c] = n + m_dl[c] + (rp + 1) * m_wd[c] + rp * m_gp[c];
      end
    end
    h3 = h2;
    h2 = h1;
    h1 = trig;
    if (wr) begin
      ch = int'(wr_addr >> 2);
      if (ch < NCH) begin
        case (wr_addr[1:0])
          2'd0: m_cd[ch] = longint'(wr_data);
          2'd1: m_cw[ch] = longint'(wr_data);
          2'd2: m_cg[ch] = longint'(wr_data);
          default: m_cr[ch] = longint'(wr_data);
        endcase
      end
    end
  endtask

  // Model advances on every clock edge, or clears on reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  // Compare all outputs against the model on every falling edge.
  initial begin
    logic [NCH-1:0] e_p, e_b, e_d;
    longint         off;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int c = 0; c < NCH; c++) begin
          off    = n - (m_st[c] + m_dl[c]);
          e_b[c] = m_act[c];
          e_d[c] = (m_done[c] == n);
          e_p[c] = m_act[c] && (off >= 0) && ((off % (m_wd[c] + m_gp[c])) < m_wd[c]);
        end
        chk("model_pulse", 64'(pulse), 64'(e_p));
        chk("model_busy",  64'(busy),  64'(e_b));
        chk("model_done",  64'(done),  64'(e_d));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wcfg(input int ch, input int r, input int d);
    wr      = 1'b1;
    wr_addr = AWB'(ch * 4 + r);
    wr_data = CW'(d);
    @(negedge clk);
    wr      = 1'b0;
  endtask

  task automatic capture(input int ch, input int len,
                         output logic [31:0] pm, output logic [31:0] dm, output logic [31:0] bm);
    pm = '0;
    dm = '0;
    bm = '0;
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      pm[j] = pulse[ch];
      dm[j] = done[ch];
      bm[j] = busy[ch];
    end
    @(negedge clk);
  endtask

  task automatic count_seq(input int ch, input int len,
                           output int highs, output int dones, output int busys);
    highs = 0;
    dones = 0;
    busys = 0;
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      highs += int'(pulse[ch]);
      dones += int'(done[ch]);
      busys += int'(busy[ch]);
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] pm, dm, bm;
    int          hi, dn, bz;
    int          rst_hold;
    int          r;

    rst_n   = 1'b0;
    trig    = '0;
    abort   = '0;
    wr      = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    n       = 0;
    model_clear();
    tick(3);
    cmp_en = 1'b1;
    chk("reset_outputs", {pulse, busy, done}, 64'h0);
    rst_n = 1'b1;
    tick(2);

    // Disabled after reset, and out-of-range channel writes are dropped.
    trig = 2'b11;
    capture(0, 10, pm, dm, bm);
    chk("disabled_ch0_busy", bm, 32'h0);
    trig = 2'b00;
    wcfg(3, 1, 7);
    wcfg(2, 1, 7);
    tick(3);
    trig = 2'b11;
    capture(1, 10, pm, dm, bm);
    chk("badaddr_ch1_busy", bm, 32'h0);
    chk("badaddr_ch1_pulse", pm, 32'h0);
    trig = 2'b00;
    tick(3);

    // DELAY=3 WIDTH=5 REPEAT=0 on channel 0.
    wcfg(0, 0, 3);
    wcfg(0, 1, 5);
    wcfg(0, 3, 0);
    tick(2);
    trig[0] = 1'b1;
    capture(0, 14, pm, dm, bm);
    chk("ch0_single_pulse", pm, 32'h3E0);
    chk("ch0_single_done",  dm, 32'h400);
    chk("ch0_single_busy",  bm, 32'h3FC);
    trig[0] = 1'b0;

    // DELAY=0 WIDTH=2 GAP=0 REPEAT=2 on channel 1.
    wcfg(1, 0, 0);
    wcfg(1, 1, 2);
    wcfg(1, 2, 0);
    wcfg(1, 3, 2);
    tick(2);
    trig[1] = 1'b1;
    capture(1, 14, pm, dm, bm);
    chk("ch1_train_pulse", pm, 32'h36C);
    chk("ch1_train_done",  dm, 32'h400);
    chk("ch1_train_busy",  bm, 32'h3FC);
    trig[1] = 1'b0;
    tick(3);

    // Retrigger and rewrite WIDTH mid-sequence: running sequence unchanged.
    trig[0] = 1'b1;
    tick(2);
    trig[0] = 1'b0;
    tick(1);
    wcfg(0, 1, 9);
    trig[0] = 1'b1;
    count_seq(0, 20, hi, dn, bz);
    chk("retrig_width_cycles", 64'(hi), 64'd5);
    chk("retrig_done_count",   64'(dn), 64'd1);
    trig[0] = 1'b0;
    tick(3);
    trig[0] = 1'b1;
    count_seq(0, 25, hi, dn, bz);
    chk("new_width_cycles", 64'(hi), 64'd9);
    chk("new_done_count",   64'(dn), 64'd1);
    trig[0] = 1'b0;
    tick(3);

    // Abort during PULSE.
    trig[0] = 1'b1;
    tick(7);
    chk("abort_pre_pulse", 64'(pulse[0]), 64'd1);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    chk("abort_pulse_low", 64'(pulse[0]), 64'd0);
    chk("abort_busy_low",  64'(busy[0]),  64'd0);
    count_seq(0, 15, hi, dn, bz);
    chk("abort_no_done", 64'(dn), 64'd0);
    trig[0] = 1'b0;
    tick(3);
    abort[0] = 1'b1;
    trig[0]  = 1'b1;
    tick(5);
    abort[0] = 1'b0;
    count_seq(0, 12, hi, dn, bz);
    chk("abort_blocks_trigger", 64'(bz), 64'd0);
    trig[0] = 1'b0;
    tick(3);

    // Asynchronous reset mid-pulse.
    trig[0] = 1'b1;
    tick(7);
    chk("rst_pre_pulse", 64'(pulse[0]), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {pulse, busy, done}, 64'h0);
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    count_seq(0, 20, hi, dn, bz);
    chk("post_reset_activity", 64'(hi + dn + bz), 64'd0);
    trig[0] = 1'b0;

    // Randomized traffic checked by the timeline model.
    for (int c = 0; c < NCH; c++) begin
      wcfg(c, 0, int'($urandom_range(0, 4)));
      wcfg(c, 1, int'($urandom_range(1, 4)));
      wcfg(c, 2, int'($urandom_range(0, 3)));
      wcfg(c, 3, int'($urandom_range(0, 3)));
    end
    rst_hold = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 999) == 0) begin
        rst_n    = 1'b0;
        rst_hold = 2;
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) trig[c] = ~trig[c];
        abort[c] = ($urandom_range(0, 63) == 0);
      end
      wr = ($urandom_range(0, 7) == 0);
      if (wr) begin
        r       = int'($urandom_range(0, 3));
        wr_addr = AWB'($urandom_range(0, 3) * 4 + r);
        case (r)
          0: wr_data = CW'($urandom_range(0, 5));
          1: wr_data = CW'($urandom_range(0, 4));
          default: wr_data = CW'($urandom_range(0, 3));
        endcase
      end
      @(negedge clk);
    end
    wr    = 1'b0;
    abort = '0;
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
